// File: rtl/register_file.sv
// ============================================================================
//  Module   : register_file
//  Purpose  : Multi-entry register bank, one write port, two registered read
//             ports with valid strobes, output gating and optional forwarding.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module register_file #(
    parameter int p_data_width = 8,
    parameter int p_addr_width = 3,
    parameter int p_depth      = 8,
    parameter int p_bypass     = 1,
    parameter int p_zero_reg   = 0
) (
    input  logic                    i_w_clk,
    input  logic                    i_w_reset,
    input  logic                    i_w_we,
    input  logic [p_addr_width-1:0] i_w_waddr,
    input  logic [p_data_width-1:0] i_w_wdata,
    input  logic                    i_w_re_a,
    input  logic [p_addr_width-1:0] i_w_raddr_a,
    input  logic                    i_w_oe_a,
    output logic [p_data_width-1:0] o_w_rdata_a,
    output logic                    o_w_rvalid_a,
    input  logic                    i_w_re_b,
    input  logic [p_addr_width-1:0] i_w_raddr_b,
    input  logic                    i_w_oe_b,
    output logic [p_data_width-1:0] o_w_rdata_b,
    output logic                    o_w_rvalid_b
);

    localparam int          c_ports = 2;
    localparam logic [31:0] c_depth = 32'(p_depth);

    generate
        if ((p_depth < 1) || (p_depth > (1 << p_addr_width))) begin : g_depth_check
            $error("register_file: p_depth must be in 1..2**p_addr_width");
        end
    endgenerate

    logic [p_data_width-1:0] mem_q    [p_depth];
    logic [p_data_width-1:0] mem_d    [p_depth];
    logic [p_data_width-1:0] rdata_q  [c_ports];
    logic [p_data_width-1:0] rdata_d  [c_ports];
    logic                    rvalid_q [c_ports];
    logic                    rvalid_d [c_ports];

    logic [p_addr_width-1:0] w_raddr  [c_ports];
    logic                    w_re     [c_ports];
    logic [p_data_width-1:0] w_entry  [c_ports];
    logic                    w_wr_accept;

    // Widen addresses before comparing so a full-size bank does not produce
    // a constant-true range test.
    function automatic logic [31:0] addr_ext(input logic [p_addr_width-1:0] a);
        return 32'(a);
    endfunction

    always_comb begin
        w_raddr[0] = i_w_raddr_a;
        w_raddr[1] = i_w_raddr_b;
        w_re[0]    = i_w_re_a;
        w_re[1]    = i_w_re_b;
    end

    // Dropped writes (out of range, or hardwired entry 0) never update state
    // and never forward.
    always_comb begin
        w_wr_accept = i_w_we
                    && (addr_ext(i_w_waddr) < c_depth)
                    && !((p_zero_reg != 0) && (i_w_waddr == '0));
    end

    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < p_depth; i++) begin
            if (w_wr_accept && (addr_ext(i_w_waddr) == 32'(i))) begin
                mem_d[i] = i_w_wdata;
            end
        end
    end

    always_comb begin
        for (int p = 0; p < c_ports; p++) begin
            w_entry[p] = '0;
            for (int i = 0; i < p_depth; i++) begin
                if (addr_ext(w_raddr[p]) == 32'(i)) begin
                    w_entry[p] = mem_q[i];
                end
            end
            if ((p_zero_reg != 0) && (w_raddr[p] == '0)) begin
                w_entry[p] = '0;
            end
            if ((p_bypass != 0) && w_wr_accept && (w_raddr[p] == i_w_waddr)) begin
                w_entry[p] = i_w_wdata;
            end
            rdata_d[p]  = w_re[p] ? w_entry[p] : rdata_q[p];
            rvalid_d[p] = w_re[p];
        end
    end

    always_ff @(posedge i_w_clk) begin
        if (i_w_reset) begin
            for (int i = 0; i < p_depth; i++) begin
                mem_q[i] <= '0;
            end
            for (int p = 0; p < c_ports; p++) begin
                rdata_q[p]  <= '0;
                rvalid_q[p] <= 1'b0;
            end
        end else begin
            mem_q <= mem_d;
            for (int p = 0; p < c_ports; p++) begin
                rdata_q[p]  <= rdata_d[p];
                rvalid_q[p] <= rvalid_d[p];
            end
        end
    end

    assign o_w_rdata_a  = i_w_oe_a ? rdata_q[0] : '0;
    assign o_w_rdata_b  = i_w_oe_b ? rdata_q[1] : '0;
    assign o_w_rvalid_a = rvalid_q[0];
    assign o_w_rvalid_b = rvalid_q[1];

endmodule

`default_nettype wire

// File: doc/register_file.md
# register_file

Parametrised multi-entry register bank, the successor to the single-word register: `p_depth` words of `p_data_width` bits with one write port and two independent read ports. Each read port has a registered, one-cycle-latency read with a valid strobe and output-enable gating. Optional write-to-read forwarding and a hardwired-zero entry 0 make it usable as a CPU general-purpose register file. It sits between the datapath's operand fetch and writeback stages.

## Interface
- `p_data_width`, 8, bits per entry.
- `p_addr_width`, 3, address bus width.
- `p_depth`, 8, number of implemented entries; must be ≤ 2**`p_addr_width`.
- `p_bypass`, 1, 1 = same-cycle write data is forwarded to a read of the same address; 0 = the read returns old contents.
- `p_zero_reg`, 0, 1 = entry 0 always reads 0 and ignores writes.

Ports:
- `i_w_clk` in 1: single clock; all state changes on the rising edge.
- `i_w_reset` in 1: reset is synchronous and active-high.
- `i_w_we` in 1: write enable.
- `i_w_waddr` in `p_addr_width`: write address.
- `i_w_wdata` in `p_data_width`: write data.
- `i_w_re_a` in 1: read request on port A.
- `i_w_raddr_a` in `p_addr_width`: read address on port A.
- `i_w_oe_a` in 1: output enable on port A; combinational gate on `o_w_rdata_a`.
- `o_w_rdata_a` out `p_data_width`: port A data. Equals the read register when `i_w_oe_a` is 1, else all zeros.
- `o_w_rvalid_a` out 1: high for the one cycle after an accepted port A read.
- `i_w_re_b`, `i_w_raddr_b`, `i_w_oe_b`, `o_w_rdata_b`, `o_w_rvalid_b`: identical to port A.

## Operation
- **Reset** (`i_w_reset`=1 at an edge):
  - All entries, both read registers and both valids are cleared to 0.
  - Reset overrides any write or read presented in the same cycle.
- **Write:**
  - At the edge, if `i_w_we`=1 and `i_w_waddr` < `p_depth`, the entry takes `i_w_wdata`.
  - Writes to address ≥ `p_depth` are dropped.
  - If `p_zero_reg`=1, writes to address 0 are also dropped.
- **Read** (per port, independent):
  - At the edge, if `re`=1, the read register loads the entry at `raddr` and `rvalid` is set to 1.
  - If `re`=0, `rvalid` is set to 0 and the read register holds its previous value.
- **Read value rules:**
  - An address ≥ `p_depth` reads 0.
  - With `p_zero_reg`=1, address 0 reads 0.
  - If a write to the same valid address occurs in the same cycle:
    - `p_bypass`=1: the read returns `i_w_wdata`.
    - `p_bypass`=0: the read returns the pre-write contents.
  - Forwarding never applies to dropped writes (address 0 with `p_zero_reg`=1, or out-of-range addresses).
- **Port independence:** both ports may read the same or different addresses in the same cycle with no conflict. There is no arbitration and no stall.
- **Output gating:**
  - `oe` affects only the data output. It does not affect `rvalid` or the stored read value.
  - `oe` may toggle any time and takes effect combinationally.

## Timing
- Write latency is 1 edge. The new value is visible to a read issued on the following edge, or on the same edge when `p_bypass`=1.
- Read latency is 1 edge: request at edge N, data and `rvalid` valid from edge N until edge N+1.
- Back-to-back reads are allowed every cycle. `rvalid` stays high continuously while `re` is held high.
- **Reset values:**
  - `o_w_rdata_a/b` = 0 regardless of `oe`.
  - `o_w_rvalid_a/b` = 0.
- **Reset mid-operation:** a read requested on the reset edge produces `rvalid`=0 and data 0 on the next cycle. A write on the reset edge is lost.
- There is no combinational path from any input to an output except `oe` → `rdata`.

## Test plan
- **Reset:**
  - Stimulus: write 0xA5 to address 3; assert reset for 1 cycle; read address 3 with `oe`=1.
  - Required: `rdata`=0x00 and `rvalid`=1 one cycle after the read. During reset, both `rvalid`=0.
- **Write/read and dual port:**
  - Stimulus: write 0x11 to address 1 and 0x22 to address 2 on consecutive cycles; then read port A at address 1 and port B at address 2 in the same cycle.
  - Required: next cycle, A=0x11 and B=0x22, both `rvalid`=1. Deasserting `oe_a` forces A=0x00 while `rvalid_a` stays 1.
- **Bypass:**
  - Stimulus: address 5 holds 0x0F; write 0xF0 to address 5 while port A reads address 5 in the same cycle.
  - Required: `p_bypass`=1 gives 0xF0; `p_bypass`=0 gives 0x0F, and the next read gives 0xF0.
- **Zero register:**
  - Stimulus: with `p_zero_reg`=1, write 0xFF to address 0 and read it back, including a same-cycle read.
  - Required: 0x00 in both cases. With `p_zero_reg`=0, the read-back returns 0xFF.
- **Out of range:**
  - Stimulus: `p_depth`=6, `p_addr_width`=3; write 0x77 to address 6, then read addresses 6 and 7.
  - Required: 0x00 for both reads, and entries 0–5 are unchanged.
- **Streaming and reset mid-stream:**
  - Stimulus: hold `re_a`=1 sweeping addresses 0–7; assert reset at the 4th edge.
  - Required: `rvalid_a` is high each cycle with the matching data, except the cycle after reset, which shows `rvalid`=0 and data 0x00. Later reads return 0.
